bpu_btb: RTL and testbench
==========================

Name: bpu_btb

Overview:
- Parametrised branch predictor for the 5-stage RV32I core: direct-mapped branch target buffer (BTB) plus a per-entry saturating-counter history table.
- Sits in IF. Gives a next-PC prediction each cycle.
- Takes resolution from EX and produces the mispredict and redirect signals that drive the IF_ID and ID_EX flushes.
- Replaces the static "always mispredicted" fetch policy, so correctly predicted branches and jumps cost zero bubbles.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, ≥2.
- TAG_W, 8, tag bits stored per entry; 1..(30-log2(ENTRIES)).
- CNT_W, 2, saturating-counter width; ≥1.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset.
- i_if_pc  in  32  PC being fetched.
- o_pred_taken  out  1  prediction for i_if_pc: taken.
- o_pred_target  out  32  predicted next PC (the target if taken, else i_if_pc+4).
- i_ex_upd_vld  in  1  EX holds a valid, unflushed branch or jump.
- i_ex_pc  in  32  PC of the EX instruction.
- i_ex_is_jmp  in  1  1 = JAL/JALR (unconditional); 0 = conditional branch.
- i_ex_taken  in  1  resolved direction (1 for jumps).
- i_ex_target  in  32  resolved target (ALU result).
- i_ex_pred_taken  in  1  prediction that was carried down the pipe with this instruction.
- i_ex_pred_target  in  32  predicted next PC carried down the pipe.
- o_mispred  out  1  EX resolution disagrees with the prediction; flush IF_ID and ID_EX.
- o_redirect_pc  out  32  correct next PC when o_mispred=1.

Behaviour:
- Clocking and reset:
  - Reset i_rst_n is synchronous, active-low; clock is i_clk.
  - While reset is low: every valid bit clears to 0 and counters clear to weakly-not-taken (MSB=0, other bits 1). The BTB is then cold, so o_pred_taken=0 and o_pred_target=i_if_pc+4.
  - Reset asserted mid-operation wins over any update in the same cycle.
- Address split: idx = pc[IDX_W+1:2] with IDX_W=log2(ENTRIES); tag = pc[IDX_W+TAG_W+1:IDX_W+2]. pc[1:0] is ignored.
- Entry contents: valid, tag, is_jmp, target[31:0], cnt[CNT_W-1:0].
- Lookup (combinational, zero latency, reads registered state only):
  - hit = valid[idx] && tag match.
  - o_pred_taken = hit && (is_jmp || cnt MSB).
  - o_pred_target = o_pred_taken ? target : i_if_pc+4.
- Mispredict check (combinational on the EX inputs, gated by i_ex_upd_vld), o_mispred is 1 if either holds:
  - direction wrong: i_ex_taken != i_ex_pred_taken;
  - target wrong: both taken and i_ex_target != i_ex_pred_target.
- o_redirect_pc = i_ex_taken ? i_ex_target : i_ex_pc+4. With i_ex_upd_vld=0, o_mispred=0.
- Update (registered, on the clock edge when i_ex_upd_vld=1):
  - Hit on i_ex_pc:
    - Counter increments if taken, decrements if not; saturates at all-1s and at 0.
    - Target and is_jmp are rewritten when taken.
  - Miss and taken: allocate (overwrite) the entry with valid=1, new tag, target, is_jmp, and cnt = weakly-taken (MSB=1, others 0).
  - Miss and not taken: no change.
- Simultaneous lookup and update at the same index: lookup returns the pre-update contents; the new contents are visible in the next cycle.
- Aliasing: entries with a partial tag may alias; this is a legal mispredict, recovered by the EX check.
- Width rule: all PC arithmetic is 32-bit modulo (0xFFFF_FFFC+4 = 0).

Optional Feature:
- Macro BPU_STATS_EN.
- Defined: adds o_br_cnt[31:0] (count of i_ex_upd_vld cycles) and o_mispred_cnt[31:0] (count of o_mispred cycles).
  - Both clear on reset and wrap modulo 2^32.
- Undefined: these ports and their counters are absent.

Decomposition:
- bpu_pkg holds:
  - typedef btb_entry_t {valid, tag, is_jmp, target, cnt};
  - the function sat_cnt_next(cnt, taken);
  - constants for CNT_WEAK_T and CNT_WEAK_NT.
- One sub-module, bpu_sat_cnt: a single CNT_W saturating counter step, instantiated per update path.

Test Plan:
- After reset, i_if_pc=0x100 → o_pred_taken=0, o_pred_target=0x104. EX update with upd_vld=0 → o_mispred=0.
- Cold taken branch:
  - EX pc=0x100, taken=1, target=0x80, pred_taken=0 → o_mispred=1, o_redirect_pc=0x80.
  - Next cycle, lookup 0x100 → pred_taken=1, target=0x80.
- Counter saturation:
  - 4 taken updates at 0x100, then 1 not-taken → still predicts taken.
  - 3 not-taken total → predicts not taken. Further not-taken updates keep the counter at 0, no wrap.
- JALR target change: entry 0x200 (is_jmp) holds target 0x400; EX taken, target=0x500 → o_mispred=1, redirect 0x500; next lookup gives 0x500.
- Alias and same-cycle collision:
  - ENTRIES=16: pc 0x100 and 0x140 share an index.
  - A same-cycle lookup of 0x140 during the 0x140 allocate returns the old entry (not-taken prediction, since the tag differs).
  - The next cycle returns the new entry.
- BPU_STATS_EN: 10 updates including 3 mispredicts → o_br_cnt=10, o_mispred_cnt=3. Reset clears both to 0.

Source files
------------

// File: rtl/bpu_pkg.sv
// rtl/bpu_pkg.sv - shared BTB entry type and saturating-counter helpers
package bpu_pkg;

  // Entries are stored at the widest legal tag/counter width; the BTB uses the low bits.
  localparam int unsigned TAG_W_MAX = 30;
  localparam int unsigned CNT_W_MAX = 8;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_MAX-1:0] tag;
    logic                 is_jmp;
    logic [31:0]          target;
    logic [CNT_W_MAX-1:0] cnt;
  } btb_entry_t;

  // All-ones value of a w-bit counter.
  function automatic logic [CNT_W_MAX-1:0] cnt_max(input int unsigned w);
    return CNT_W_MAX'((9'(1) << w) - 9'(1));
  endfunction

  // Weakly taken: MSB set, other bits clear.
  function automatic logic [CNT_W_MAX-1:0] cnt_weak_t(input int unsigned w);
    return CNT_W_MAX'(9'(1) << (w - 1));
  endfunction

  // Weakly not taken: MSB clear, other bits set.
  function automatic logic [CNT_W_MAX-1:0] cnt_weak_nt(input int unsigned w);
    return cnt_weak_t(w) - CNT_W_MAX'(1);
  endfunction

  // One saturating step of a w-bit counter towards taken or not taken.
  function automatic logic [CNT_W_MAX-1:0] sat_cnt_next(input logic [CNT_W_MAX-1:0] cnt,
                                                        input logic taken,
                                                        input int unsigned w);
    logic [CNT_W_MAX-1:0] nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != cnt_max(w)) nxt = cnt + CNT_W_MAX'(1);
    end else begin
      if (cnt != '0) nxt = cnt - CNT_W_MAX'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bpu_sat_cnt.sv
// rtl/bpu_sat_cnt.sv - single saturating history counter step
module bpu_sat_cnt
  import bpu_pkg::*;
#(
  parameter int unsigned CNT_W = 2
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic             taken,
  output logic [CNT_W-1:0] cnt_next
);

  // Counter width is at most CNT_W_MAX, so widening then narrowing is lossless.
  assign cnt_next = CNT_W'(sat_cnt_next(CNT_W_MAX'(cnt), taken, CNT_W));

endmodule

// File: rtl/bpu_btb.sv
// rtl/bpu_btb.sv - direct-mapped BTB with saturating-counter predictor (optional stats: BPU_STATS_EN)
module bpu_btb
  import bpu_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned CNT_W   = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_if_pc,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  input  logic        i_ex_upd_vld,
  input  logic [31:0] i_ex_pc,
  input  logic        i_ex_is_jmp,
  input  logic        i_ex_taken,
  input  logic [31:0] i_ex_target,
  input  logic        i_ex_pred_taken,
  input  logic [31:0] i_ex_pred_target,
  output logic        o_mispred,
  output logic [31:0] o_redirect_pc
`ifdef BPU_STATS_EN
  ,
  output logic [31:0] o_br_cnt,
  output logic [31:0] o_mispred_cnt
`endif
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_W'(cnt_weak_t(CNT_W));
  localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_W'(cnt_weak_nt(CNT_W));

  btb_entry_t tbl [ENTRIES];

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] if_tag;
  logic [TAG_W-1:0] ex_tag;
  btb_entry_t       lk_entry;
  btb_entry_t       up_entry;
  logic             lk_hit;
  logic             up_hit;
  logic [CNT_W-1:0] cnt_upd;
  logic             dir_wrong;
  logic             tgt_wrong;
  logic             unused_fields;

  assign if_idx = i_if_pc[IDX_W+1:2];
  assign if_tag = i_if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign ex_idx = i_ex_pc[IDX_W+1:2];
  assign ex_tag = i_ex_pc[IDX_W+TAG_W+1:IDX_W+2];

  // Both ports read registered state, so a same-index update shows up one cycle later.
  assign lk_entry = tbl[if_idx];
  assign up_entry = tbl[ex_idx];

  // Stored fields are wider than the configured tag/counter; the upper bits stay zero.
  assign unused_fields = ^{lk_entry.tag, lk_entry.cnt, up_entry.tag, up_entry.cnt,
                           up_entry.is_jmp, up_entry.target};

  // Fetch-side lookup: taken on a hit that is a jump or has the counter MSB set.
  always_comb begin
    lk_hit        = lk_entry.valid && (lk_entry.tag[TAG_W-1:0] == if_tag);
    o_pred_taken  = lk_hit && (lk_entry.is_jmp || lk_entry.cnt[CNT_W-1]);
    o_pred_target = o_pred_taken ? lk_entry.target : i_if_pc + 32'd4;
  end

  // EX-side check of the carried prediction against the resolved outcome.
  always_comb begin
    dir_wrong     = i_ex_taken != i_ex_pred_taken;
    tgt_wrong     = i_ex_taken && i_ex_pred_taken && (i_ex_target != i_ex_pred_target);
    o_mispred     = i_ex_upd_vld && (dir_wrong || tgt_wrong);
    o_redirect_pc = i_ex_taken ? i_ex_target : i_ex_pc + 32'd4;
    up_hit        = up_entry.valid && (up_entry.tag[TAG_W-1:0] == ex_tag);
  end

  bpu_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_upd_cnt (
    .cnt     (up_entry.cnt[CNT_W-1:0]),
    .taken   (i_ex_taken),
    .cnt_next(cnt_upd)
  );

  // Table update: train on hit, allocate on taken miss, reset clears everything.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tbl[i] <= '{valid: 1'b0, tag: '0, is_jmp: 1'b0, target: '0,
                    cnt: CNT_W_MAX'(CNT_WEAK_NT)};
      end
    end else if (i_ex_upd_vld) begin
      if (up_hit) begin
        tbl[ex_idx].cnt <= CNT_W_MAX'(cnt_upd);
        if (i_ex_taken) begin
          tbl[ex_idx].target <= i_ex_target;
          tbl[ex_idx].is_jmp <= i_ex_is_jmp;
        end
      end else if (i_ex_taken) begin
        tbl[ex_idx] <= '{valid: 1'b1, tag: TAG_W_MAX'(ex_tag), is_jmp: i_ex_is_jmp,
                         target: i_ex_target, cnt: CNT_W_MAX'(CNT_WEAK_T)};
      end
    end
  end

`ifdef BPU_STATS_EN
  // Resolved-branch and mispredict event counters, wrapping modulo 2^32.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_br_cnt      <= '0;
      o_mispred_cnt <= '0;
    end else begin
      if (i_ex_upd_vld) o_br_cnt <= o_br_cnt + 32'd1;
      if (o_mispred) o_mispred_cnt <= o_mispred_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bpu_btb.sv
// tb/tb_bpu_btb.sv - self-checking bench for bpu_btb (stats checks under BPU_STATS_EN)
module tb_bpu_btb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_vld;
  logic [31:0] ex_pc;
  logic        ex_is_jmp;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispred;
  logic [31:0] redirect_pc;
`ifdef BPU_STATS_EN
  logic [31:0] br_cnt;
  logic [31:0] mispred_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bpu_btb dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_if_pc         (if_pc),
    .o_pred_taken    (pred_taken),
    .o_pred_target   (pred_target),
    .i_ex_upd_vld    (upd_vld),
    .i_ex_pc         (ex_pc),
    .i_ex_is_jmp     (ex_is_jmp),
    .i_ex_taken      (ex_taken),
    .i_ex_target     (ex_target),
    .i_ex_pred_taken (ex_pred_taken),
    .i_ex_pred_target(ex_pred_target),
    .o_mispred       (mispred),
    .o_redirect_pc   (redirect_pc)
`ifdef BPU_STATS_EN
    ,
    .o_br_cnt        (br_cnt),
    .o_mispred_cnt   (mispred_cnt)
`endif
  );

  // Reference model: 16 entries, 8-bit tag, counter held as an integer 0..3.
  bit          m_valid [16];
  int          m_tag   [16];
  bit          m_jmp   [16];
  logic [31:0] m_tgt   [16];
  int          m_cnt   [16];
  int unsigned m_br;
  int unsigned m_mis;
  bit          m_ready = 1'b0;

  function automatic int pc_idx(input logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  function automatic int pc_tag(input logic [31:0] pc);
    return int'((pc >> 6) % 256);
  endfunction

  function automatic logic m_hit(input logic [31:0] pc);
    return m_valid[pc_idx(pc)] && (m_tag[pc_idx(pc)] == pc_tag(pc));
  endfunction

  function automatic logic exp_taken(input logic [31:0] pc);
    return m_hit(pc) && (m_jmp[pc_idx(pc)] || m_cnt[pc_idx(pc)] >= 2);
  endfunction

  function automatic logic [31:0] exp_target(input logic [31:0] pc);
    return exp_taken(pc) ? m_tgt[pc_idx(pc)] : pc + 32'd4;
  endfunction

  function automatic logic exp_mispred();
    if (!upd_vld) return 1'b0;
    if (ex_taken != ex_pred_taken) return 1'b1;
    return ex_taken && (ex_target != ex_pred_target);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state follows the same clock edge the DUT trains on.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i] <= 1'b0;
        m_cnt[i]   <= 1;
      end
      m_br    <= 0;
      m_mis   <= 0;
      m_ready <= 1'b1;
    end else if (upd_vld) begin
      m_br <= m_br + 1;
      if (exp_mispred()) m_mis <= m_mis + 1;
      if (m_hit(ex_pc)) begin
        m_cnt[pc_idx(ex_pc)] <= ex_taken ? ((m_cnt[pc_idx(ex_pc)] == 3) ? 3 : m_cnt[pc_idx(ex_pc)] + 1)
                                         : ((m_cnt[pc_idx(ex_pc)] == 0) ? 0 : m_cnt[pc_idx(ex_pc)] - 1);
        if (ex_taken) begin
          m_tgt[pc_idx(ex_pc)] <= ex_target;
          m_jmp[pc_idx(ex_pc)] <= ex_is_jmp;
        end
      end else if (ex_taken) begin
        m_valid[pc_idx(ex_pc)] <= 1'b1;
        m_tag[pc_idx(ex_pc)]   <= pc_tag(ex_pc);
        m_tgt[pc_idx(ex_pc)]   <= ex_target;
        m_jmp[pc_idx(ex_pc)]   <= ex_is_jmp;
        m_cnt[pc_idx(ex_pc)]   <= 2;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (m_ready) begin
      chk("pred_taken", 32'(pred_taken), 32'(exp_taken(if_pc)));
      chk("pred_target", pred_target, exp_target(if_pc));
      chk("mispred", 32'(mispred), 32'(exp_mispred()));
      chk("redirect_pc", redirect_pc, ex_taken ? ex_target : ex_pc + 32'd4);
`ifdef BPU_STATS_EN
      chk("br_cnt", br_cnt, 32'(m_br));
      chk("mispred_cnt", mispred_cnt, 32'(m_mis));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic half();
    @(negedge clk);
  endtask

  task automatic ex_set(input logic v, input logic [31:0] pc, input logic jmp, input logic tk,
                        input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    upd_vld        = v;
    ex_pc          = pc;
    ex_is_jmp      = jmp;
    ex_taken       = tk;
    ex_target      = tgt;
    ex_pred_taken  = ptk;
    ex_pred_target = ptgt;
  endtask

  task automatic ex_idle();
    ex_set(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    if_pc = 32'h100;
    ex_idle();
    tick();
    tick();
    rst_n = 1'b1;
    half();
    chk("lit_reset_pred_taken", 32'(pred_taken), 32'd0);
    chk("lit_reset_pred_target", pred_target, 32'h104);

    // Invalid EX slot never mispredicts even with disagreeing fields.
    tick();
    ex_set(1'b0, 32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
    half();
    chk("lit_novld_mispred", 32'(mispred), 32'd0);

    // Cold taken branch.
    tick();
    ex_set(1'b1, 32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
    half();
    chk("lit_cold_mispred", 32'(mispred), 32'd1);
    chk("lit_cold_redirect", redirect_pc, 32'h80);
    chk("lit_cold_same_cycle", 32'(pred_taken), 32'd0);
    tick();
    ex_idle();
    half();
    chk("lit_alloc_taken", 32'(pred_taken), 32'd1);
    chk("lit_alloc_target", pred_target, 32'h80);

    // Saturate high, then walk down.
    for (int k = 0; k < 4; k++) begin
      tick();
      ex_set(1'b1, 32'h100, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80);
    end
    half();
    chk("lit_correct_no_mispred", 32'(mispred), 32'd0);
    tick();
    ex_set(1'b1, 32'h100, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80);
    half();
    chk("lit_nt_redirect", redirect_pc, 32'h104);
    chk("lit_nt_mispred", 32'(mispred), 32'd1);
    tick();
    ex_idle();
    half();
    chk("lit_sat_one_nt", 32'(pred_taken), 32'd1);
    for (int k = 0; k < 2; k++) begin
      tick();
      ex_set(1'b1, 32'h100, 1'b0, 1'b0, 32'h80, 1'b0, 32'h104);
    end
    tick();
    ex_idle();
    half();
    chk("lit_three_nt", 32'(pred_taken), 32'd0);
    chk("lit_three_nt_target", pred_target, 32'h104);
    for (int k = 0; k < 2; k++) begin
      tick();
      ex_set(1'b1, 32'h100, 1'b0, 1'b0, 32'h80, 1'b0, 32'h104);
    end
    tick();
    ex_set(1'b1, 32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
    tick();
    ex_idle();
    half();
    chk("lit_floor_no_wrap", 32'(pred_taken), 32'd0);
    tick();
    ex_set(1'b1, 32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
    tick();
    ex_idle();
    half();
    chk("lit_back_to_taken", 32'(pred_taken), 32'd1);

    // JALR at 0x200 evicts 0x100 (same index), then changes target.
    tick();
    if_pc = 32'h200;
    ex_set(1'b1, 32'h200, 1'b1, 1'b1, 32'h400, 1'b0, 32'h204);
    tick();
    ex_idle();
    half();
    chk("lit_jmp_target", pred_target, 32'h400);
    tick();
    ex_set(1'b1, 32'h200, 1'b1, 1'b1, 32'h500, 1'b1, 32'h400);
    half();
    chk("lit_jmp_mispred", 32'(mispred), 32'd1);
    chk("lit_jmp_redirect", redirect_pc, 32'h500);
    tick();
    ex_idle();
    half();
    chk("lit_jmp_new_target", pred_target, 32'h500);
    tick();
    if_pc = 32'h100;
    half();
    chk("lit_evicted", pred_target, 32'h104);

    // Alias collision: lookup during allocate sees the old entry.
    tick();
    if_pc = 32'h140;
    ex_set(1'b1, 32'h140, 1'b0, 1'b1, 32'h300, 1'b0, 32'h144);
    half();
    chk("lit_collide_old", 32'(pred_taken), 32'd0);
    chk("lit_collide_old_tgt", pred_target, 32'h144);
    tick();
    ex_idle();
    half();
    chk("lit_collide_new", pred_target, 32'h300);

    // 32-bit wrap of PC+4.
    tick();
    if_pc = 32'hFFFF_FFFC;
    ex_set(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1234);
    half();
    chk("lit_wrap_pred", pred_target, 32'h0);
    chk("lit_wrap_redirect", redirect_pc, 32'h0);
    chk("lit_wrap_mispred", 32'(mispred), 32'd1);

    // Reset wins over a same-cycle update.
    tick();
    rst_n = 1'b0;
    if_pc = 32'h140;
    ex_set(1'b1, 32'h300, 1'b0, 1'b1, 32'h700, 1'b0, 32'h304);
    tick();
    rst_n = 1'b1;
    ex_idle();
    if_pc = 32'h300;
    half();
    chk("lit_rst_wins", pred_target, 32'h304);
    tick();
    if_pc = 32'h140;
    half();
    chk("lit_rst_cleared", 32'(pred_taken), 32'd0);

    // Ten updates, three with a wrong direction prediction.
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 0 || k == 4 || k == 7)
        ex_set(1'b1, 32'h10, 1'b0, 1'b1, 32'h20, 1'b0, 32'h14);
      else
        ex_set(1'b1, 32'h10, 1'b0, 1'b1, 32'h20, 1'b1, 32'h20);
    end
    tick();
    ex_idle();
    half();
`ifdef BPU_STATS_EN
    chk("lit_stats_br", br_cnt, 32'd10);
    chk("lit_stats_mis", mispred_cnt, 32'd3);
`endif
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    half();
`ifdef BPU_STATS_EN
    chk("lit_stats_br_rst", br_cnt, 32'd0);
    chk("lit_stats_mis_rst", mispred_cnt, 32'd0);
`endif
    chk("lit_final_cold", 32'(pred_taken), 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
